// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// pad byte used to complete a word whose low byte never arrived.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/prog_ram.sv
// Instruction store: DEPTH x 16, synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives clear.
module prog_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Loads a byte-streamed program into the instruction store and serves
// CPU fetches once a complete load has finished.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter  int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [15:0]       pc,
    output logic [15:0]       ins,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_end,
    output logic              load_ready,
    output logic              cpu_clear,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_e          state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [ADDR_W:0] wc_q, wc_d;
    logic            ovf_q, ovf_d;
    logic            cpu_clear_q, cpu_clear_d;
    logic            do_write;
    logic            we;
    logic [15:0]     wdata;
    logic [15:0]     rdata;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            wc_q        <= '0;
            ovf_q       <= 1'b0;
            cpu_clear_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            wc_q        <= wc_d;
            ovf_q       <= ovf_d;
            cpu_clear_q <= cpu_clear_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        wc_d     = wc_q;
        ovf_d    = ovf_q;
        do_write = 1'b0;
        we       = 1'b0;
        wdata    = {hi_q, load_byte};

        // load_end wins over load_valid; a pending high byte is padded out
        case (state_q)
            IDLE, RUN: begin
                if (load_start) begin
                    state_d = WAIT_HI;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                end
            end
            WAIT_HI: begin
                if (load_end) begin
                    state_d = RUN;
                end else if (load_valid) begin
                    hi_d    = load_byte;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (load_end) begin
                    do_write = 1'b1;
                    wdata    = {hi_q, PAD_BYTE};
                    state_d  = RUN;
                end else if (load_valid) begin
                    do_write = 1'b1;
                    state_d  = WAIT_HI;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_write) begin
            if (wc_q == FULL_COUNT) begin
                ovf_d = 1'b1;
            end else begin
                we   = 1'b1;
                wc_d = wc_q + 1'b1;
            end
        end

        cpu_clear_d = (state_d != RUN);
    end

    prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wc_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (pc[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

    assign ins        = (state_q == RUN && pc < 16'(wc_q)) ? rdata : 16'h0000;
    assign load_ready = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign cpu_clear  = cpu_clear_q;
    assign word_count = wc_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a full-size and a DEPTH=4 instance share
// the same stimulus; expected words are queued as bytes are sent.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        clear;
    logic [15:0] pc;
    logic        load_start, load_valid, load_end;
    logic [7:0]  load_byte;

    logic [15:0] ins_b, ins_s;
    logic        ready_b, ready_s, cpuclr_b, cpuclr_s, ovf_b, ovf_s;
    logic [8:0]  wc_b;
    logic [2:0]  wc_s;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [15:0] big_q[$];
    logic [15:0] small_q[$];
    logic        small_ovf = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(256)) dut_big (
        .clk(clk), .clear(clear), .pc(pc), .ins(ins_b),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_end(load_end), .load_ready(ready_b), .cpu_clear(cpuclr_b),
        .word_count(wc_b), .overflow(ovf_b)
    );

    prog_loader #(.DEPTH(4)) dut_small (
        .clk(clk), .clear(clear), .pc(pc), .ins(ins_s),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_end(load_end), .load_ready(ready_s), .cpu_clear(cpuclr_s),
        .word_count(wc_s), .overflow(ovf_s)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        big_q.delete();
        small_q.delete();
        small_ovf = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] w);
        big_q.push_back(w);
        if (small_q.size() < 4) small_q.push_back(w);
        else small_ovf = 1'b1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        model_push(w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic end_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    // Compare both instances against the model, draining the expected queues.
    task automatic verify(input string tag);
        int unsigned nb, ns;
        nb = big_q.size();
        ns = small_q.size();
        chk({tag, "/wc_big"},    16'(wc_b),     16'(nb));
        chk({tag, "/wc_small"},  16'(wc_s),     16'(ns));
        chk({tag, "/ovf_big"},   16'(ovf_b),    16'h0000);
        chk({tag, "/ovf_small"}, 16'(ovf_s),    16'(small_ovf));
        chk({tag, "/cpuclr"},    16'(cpuclr_b), 16'h0000);
        chk({tag, "/ready"},     16'(ready_b),  16'h0000);
        for (int unsigned i = 0; i <= nb; i++) begin
            pc = 16'(i);
            #1;
            chk({tag, "/ins_big"}, ins_b, (i < nb) ? big_q.pop_front() : 16'h0000);
        end
        for (int unsigned i = 0; i <= ns; i++) begin
            pc = 16'(i);
            #1;
            chk({tag, "/ins_small"}, ins_s, (i < ns) ? small_q.pop_front() : 16'h0000);
        end
    endtask

    initial begin
        clear = 1'b1; pc = '0;
        load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_byte = '0;
        tick();
        chk("rst/cpuclr", 16'(cpuclr_b), 16'h0001);
        chk("rst/ready",  16'(ready_b),  16'h0000);
        chk("rst/ins",    ins_b,         16'h0000);
        chk("rst/wc",     16'(wc_b),     16'h0000);
        clear = 1'b0;
        tick();
        chk("idle/cpuclr", 16'(cpuclr_b), 16'h0001);

        // Two full words
        start_load();
        chk("load1/ready",  16'(ready_b),  16'h0001);
        chk("load1/cpuclr", 16'(cpuclr_b), 16'h0001);
        send_word(16'h1234);
        send_word(16'hABCD);
        end_load();
        verify("load1");

        // Restart from RUN, single high byte then end -> padded word
        start_load();
        chk("load2/cpuclr_rise", 16'(cpuclr_b), 16'h0001);
        chk("load2/ins_gated",   ins_b,         16'h0000);
        model_push({8'h56, 8'h00});
        send_byte(8'h56);
        end_load();
        verify("load2");

        // load_valid and load_end together in WAIT_LO
        start_load();
        model_push({8'h77, 8'h00});
        send_byte(8'h77);
        load_valid = 1'b1; load_byte = 8'h88; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        verify("both");

        // Five words: small instance overflows
        start_load();
        send_word(16'h0102);
        send_word(16'h0304);
        send_word(16'h0506);
        send_word(16'h0708);
        send_word(16'h090A);
        end_load();
        verify("ovf");

        // New load clears overflow; immediate end gives an empty program
        start_load();
        chk("ovfclr/ovf",   16'(ovf_s),   16'h0000);
        chk("ovfclr/ready", 16'(ready_s), 16'h0001);
        end_load();
        verify("empty");

        // Clear mid-load after three bytes
        start_load();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        clear = 1'b1;
        #1;
        chk("midclr/ready",  16'(ready_b),  16'h0000);
        chk("midclr/cpuclr", 16'(cpuclr_b), 16'h0001);
        chk("midclr/wc",     16'(wc_b),     16'h0000);
        tick();
        clear = 1'b0;
        model_reset();
        pc = '0;
        #1;
        chk("midclr/ins", ins_b, 16'h0000);
        start_load();
        send_word(16'hAABB);
        end_load();
        verify("reload");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
